// File: rtl/pattern_scan_pkg.sv
// Shared definitions for the pattern scan controller and its serial match core.
package pattern_scan_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned PAT_MAX_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned LEN_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pattern_match_core.sv
// Overlapping Moore-style serial matcher: history shift register, bits-seen
// counter and length-masked compare against the programmed pattern.
module pattern_match_core
  import pattern_scan_pkg::*;
#(
  parameter int unsigned PAT_MAX = PAT_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_en,
  input  logic               clear,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match_c,
  output logic               det_pulse
);

  logic [PAT_MAX-1:0] history;
  logic [PAT_MAX-1:0] hist_d;
  logic [PAT_MAX-1:0] mask;
  logic [LEN_W-1:0]   bits_seen;
  logic [LEN_W-1:0]   seen_d;

  // Evaluate the match on the history as it will look after this bit.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    hist_d  = {history[PAT_MAX-2:0], bit_in};
    seen_d  = (bits_seen >= LEN_W'(PAT_MAX)) ? bits_seen : bits_seen + LEN_W'(1);
    match_c = bit_en && (len != '0) && (seen_d >= len) &&
              (((hist_d ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history   <= '0;
      bits_seen <= '0;
      det_pulse <= 1'b0;
    end else begin
      det_pulse <= match_c;
      if (clear) begin
        history   <= '0;
        bits_seen <= '0;
      end else if (bit_en) begin
        history   <= hist_d;
        bits_seen <= seen_d;
      end
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame-level scheduler: accepts words over valid/ready, serializes them MSB-first
// into the match core, and keeps a saturating match count with a sticky threshold flag.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned PAT_MAX = PAT_MAX_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               thresh_hit
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e             state;
  state_e             state_d;
  logic [DATA_W-1:0]  word_q;
  logic               last_q;
  logic [IDX_W-1:0]   bit_idx;
  logic [PAT_MAX-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   thr_q;

  logic               cfg_take_c;
  logic               start_c;
  logic               capture_c;
  logic               shift_c;
  logic               match_c;
  logic [LEN_W-1:0]   len_clamp_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  always_comb begin
    state_d   = state;
    cfg_take_c = 1'b0;
    start_c   = 1'b0;
    capture_c = 1'b0;
    shift_c   = 1'b0;
    case (state)
      IDLE: begin
        cfg_take_c = cfg_we;
        if (start) begin
          start_c = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          capture_c = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_c = 1'b1;
        if (bit_idx == '0) begin
          state_d = last_q ? DONE : LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_clamp_c = (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
    cnt_inc_c   = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
  end

  // Status outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      in_ready <= (state_d == LOAD);
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
      len_q <= '0;
      thr_q <= '0;
    end else if (cfg_take_c) begin
      pat_q <= cfg_pattern;
      len_q <= len_clamp_c;
      thr_q <= cfg_thresh;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q  <= '0;
      last_q  <= 1'b0;
      bit_idx <= '0;
    end else if (capture_c) begin
      word_q  <= in_data;
      last_q  <= in_last;
      bit_idx <= IDX_W'(DATA_W - 1);
    end else if (shift_c && (bit_idx != '0)) begin
      bit_idx <= bit_idx - IDX_W'(1);
    end
  end

  // Count lands on the same edge as det_pulse, using the core's combinational match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt  <= '0;
      thresh_hit <= 1'b0;
    end else if (start_c) begin
      match_cnt  <= '0;
      thresh_hit <= 1'b0;
    end else if (match_c) begin
      match_cnt <= cnt_inc_c;
      if ((thr_q != '0) && (cnt_inc_c >= thr_q)) begin
        thresh_hit <= 1'b1;
      end
    end
  end

  pattern_match_core #(
    .PAT_MAX (PAT_MAX)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (word_q[bit_idx]),
    .bit_en    (shift_c),
    .clear     (start_c),
    .pattern   (pat_q),
    .len       (len_q),
    .match_c   (match_c),
    .det_pulse (det_pulse)
  );

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench: directed and randomized scans checked cycle by cycle
// against a bit-string reference model of the matcher.
module tb_pattern_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_thresh;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       det_pulse;
  logic [7:0] match_cnt;
  logic       thresh_hit;

  pattern_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_thresh  (cfg_thresh),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .busy        (busy),
    .done        (done),
    .det_pulse   (det_pulse),
    .match_cnt   (match_cnt),
    .thresh_hit  (thresh_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;

  // Reference model state
  logic [7:0] m_pat;
  int         m_len;
  int         m_thr;
  int         m_cnt;
  bit         m_hit;
  bit         sbits[$];
  logic [7:0] wq[16];
  int         sq[16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Match after stream bit k: the newest len bits equal pattern[len-1:0].
  function automatic bit exp_match(input int k);
    if (m_len == 0 || k + 1 < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (sbits[k-j] != m_pat[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock edge; ph = phase after the edge (0 idle,1 load,2 shift,3 done),
  // k = stream index of the bit shifted on this edge, or -1.
  task automatic tick(input int ph, input int k);
    bit e_det;
    @(posedge clk);
    #1;
    e_det = (k >= 0) ? exp_match(k) : 1'b0;
    if (e_det) begin
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      if (m_thr != 0 && m_cnt >= m_thr) m_hit = 1'b1;
    end
    chk("in_ready",   32'(in_ready),   32'(ph == 1));
    chk("busy",       32'(busy),       32'(ph != 0));
    chk("done",       32'(done),       32'(ph == 3));
    chk("det_pulse",  32'(det_pulse),  32'(e_det));
    chk("match_cnt",  32'(match_cnt),  32'(m_cnt));
    chk("thresh_hit", 32'(thresh_hit), 32'(m_hit));
  endtask

  task automatic configure(input logic [7:0] pat, input int len, input int thr);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = 4'(len);
    cfg_thresh  = 8'(thr);
    tick(0, -1);
    cfg_we = 1'b0;
    m_pat  = pat;
    m_len  = (len > 8) ? 8 : len;
    m_thr  = thr;
  endtask

  // Scan nw words from wq with sq[w] stall cycles before each; poke fires
  // ignored cfg_we/start during the first word's shifting.
  task automatic run_scan(input int nw, input bit poke);
    int k;
    k = 0;
    sbits.delete();
    for (int w = 0; w < nw; w++)
      for (int b = 7; b >= 0; b--) sbits.push_back(wq[w][b]);
    m_cnt = 0;
    m_hit = 1'b0;
    start = 1'b1;
    tick(1, -1);
    start = 1'b0;
    for (int w = 0; w < nw; w++) begin
      in_valid = 1'b0;
      for (int s = 0; s < sq[w]; s++) begin
        in_data = 8'($urandom);
        in_last = 1'($urandom);
        tick(1, -1);
      end
      in_valid = 1'b1;
      in_data  = wq[w];
      in_last  = (w == nw - 1);
      tick(2, -1);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      for (int b = 0; b < 8; b++) begin
        if (poke && w == 0 && b == 3) begin
          cfg_we      = 1'b1;
          cfg_len     = 4'd2;
          cfg_pattern = ~m_pat;
          cfg_thresh  = 8'd1;
          start       = 1'b1;
        end
        tick((b == 7) ? ((w == nw - 1) ? 3 : 1) : 2, k);
        k++;
        cfg_we = 1'b0;
        start  = 1'b0;
      end
    end
    tick(0, -1);
  endtask

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
    start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    m_pat = '0; m_len = 0; m_thr = 0; m_cnt = 0; m_hit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_cnt",      32'(match_cnt), 32'd0);
    #2 rst = 1'b1;

    // Two overlapping matches in one word
    configure(8'b0001_0101, 5, 0);
    wq[0] = 8'b1010_1010; sq[0] = 0;
    run_scan(1, 1'b0);

    // Match spanning a word boundary
    wq[0] = 8'b0000_0101; wq[1] = 8'b0100_0000; sq[0] = 0; sq[1] = 0;
    run_scan(2, 1'b0);

    // Single-bit pattern, threshold crossing mid-word
    configure(8'h01, 1, 3);
    wq[0] = 8'hFF; sq[0] = 0;
    run_scan(1, 1'b0);

    // Config/start pokes during SHIFT are ignored; later start clears count
    wq[0] = 8'hF0; wq[1] = 8'h3C; sq[0] = 0; sq[1] = 1;
    run_scan(2, 1'b1);
    configure(8'b0001_0101, 5, 1);
    wq[0] = 8'h00; sq[0] = 0;
    run_scan(1, 1'b0);

    // Input stall in LOAD
    wq[0] = 8'hAA; wq[1] = 8'hAB; sq[0] = 5; sq[1] = 5;
    run_scan(2, 1'b0);

    // Length clamp above PAT_MAX
    configure(8'hA5, 13, 1);
    wq[0] = 8'hA5; wq[1] = 8'hA5; sq[0] = 0; sq[1] = 2;
    run_scan(2, 1'b0);

    // Randomized scans
    for (int it = 0; it < 25; it++) begin
      int nw;
      configure(8'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 6)));
      nw = int'($urandom_range(1, 4));
      for (int w = 0; w < nw; w++) begin
        wq[w] = 8'($urandom);
        sq[w] = int'($urandom_range(0, 3));
      end
      run_scan(nw, 1'($urandom));
    end

    // Asynchronous reset mid-SHIFT
    configure(8'b0001_0101, 5, 1);
    sbits.delete();
    for (int b = 7; b >= 0; b--) sbits.push_back(1'(b % 2));
    m_cnt = 0; m_hit = 1'b0;
    start = 1'b1;
    tick(1, -1);
    start    = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b1;
    tick(2, -1);
    in_valid = 1'b0;
    tick(2, 0);
    tick(2, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready),   32'd0);
    chk("arst_busy",     32'(busy),       32'd0);
    chk("arst_done",     32'(done),       32'd0);
    chk("arst_det",      32'(det_pulse),  32'd0);
    chk("arst_cnt",      32'(match_cnt),  32'd0);
    chk("arst_hit",      32'(thresh_hit), 32'd0);
    m_pat = '0; m_len = 0; m_thr = 0; m_cnt = 0; m_hit = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done), 32'd0);
    #2 rst = 1'b1;
    wq[0] = 8'hFF; wq[1] = 8'h00; sq[0] = 0; sq[1] = 0;
    run_scan(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
- Controller that sequences a serial, overlapping, Moore-style pattern detector over a stream of parallel words.
- Accepts words through a valid/ready handshake and serializes each one MSB-first, one bit per clock, into a programmable pattern matcher (up to PAT_MAX bits).
- Counts matches and raises a sticky threshold flag.
- Sits between a word-oriented producer and status/interrupt logic; this is the frame-level scheduler for the sequence-detector datapath.

Parameters:
- DATA_W, 8: width of input words, serialized MSB-first.
- PAT_MAX, 8: maximum pattern length in bits.
- CNT_W, 8: width of the match counter and the threshold.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cfg_we  in  1  config write strobe; honoured only in IDLE.
- cfg_pattern  in  PAT_MAX  pattern; bit cfg_len-1 is the first bit received.
- cfg_len  in  4  pattern length; 0 disables detection; values above PAT_MAX clamp to PAT_MAX.
- cfg_thresh  in  CNT_W  match-count threshold; 0 disables thresh_hit.
- start  in  1  begins a scan; honoured only in IDLE.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  input word.
- in_last  in  1  marks the final word of the scan.
- in_ready  out  1  high only in LOAD.
- busy  out  1  high in LOAD, SHIFT and DONE.
- done  out  1  one-cycle pulse in DONE.
- det_pulse  out  1  registered pulse, one per match.
- match_cnt  out  CNT_W  saturating match count.
- thresh_hit  out  1  sticky: set when match_cnt >= cfg_thresh (cfg_thresh != 0).

Behaviour:
- Reset, asynchronous with rst=0:
  - State goes to IDLE.
  - All outputs go to 0; match_cnt = 0.
  - History, bits-seen counter, word register and config registers clear. Pattern and length reset to 0, so detection is disabled.
  - Reset mid-scan abandons the word; no done pulse is produced.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: cfg_we latches pattern, clamped len and thresh.
  - IDLE, start=1: clear history, bits_seen, match_cnt and thresh_hit, then go to LOAD. If cfg_we and start arrive in the same cycle, the new config is used.
  - LOAD: in_ready=1. When in_valid=1, capture in_data and in_last, set bit_idx=DATA_W-1, go to SHIFT. When in_valid=0, hold with no shifting (stall).
  - SHIFT: each cycle shift word bit[bit_idx] into history[0] (older bits move up) and increment bits_seen, saturating at PAT_MAX.
    - After the bit with bit_idx=0: go to DONE if the captured last=1, otherwise to LOAD.
    - Throughput: DATA_W+1 cycles per word with no stalls.
  - DONE: done=1 for one cycle, then IDLE.
- cfg_we and start are ignored outside IDLE; config stays stable during a scan.
- Match rule, evaluated on every shifted bit:
  - Condition: len != 0, bits_seen (including the current bit) >= len, and history[len-1:0] == pattern[len-1:0].
  - Overlapping: history is never cleared on a match.
  - History carries across word boundaries within one scan.
- Match outputs:
  - det_pulse is registered: high in the cycle after the completing bit is shifted.
  - match_cnt increments in that same cycle and saturates at 2^CNT_W-1.
  - thresh_hit sets in the same cycle match_cnt reaches cfg_thresh, and stays set until the next start or reset.
- Simultaneous events: a det_pulse may coincide with the first LOAD or DONE cycle; it is still counted.

Decomposition:
- Shared package pattern_scan_pkg holds:
  - State encoding: IDLE=2'd0, LOAD=2'd1, SHIFT=2'd2, DONE=2'd3.
  - Default DATA_W, PAT_MAX and CNT_W constants.
- One sub-module, pattern_match_core, holds the history shift register, bits_seen, the length mask/compare and the registered det_pulse.
  - Interface: bit_in, bit_en, clear, pattern, len → det_pulse.
  - pattern_scan_ctrl owns the FSM, handshake, counter and threshold logic.

Test Plan:
1. pattern=5'b10101, len=5; single word 8'b10101010 with last → det_pulse twice, 2 cycles apart, after bits 5 and 7; match_cnt=2; done 1 cycle after the final bit.
2. Same pattern; words 8'b00000101, then 8'b01000000 with last → one match, spanning the boundary, after the 2nd bit of word 2; match_cnt=1.
3. pattern=1'b1, len=1, thresh=3; word 8'hFF with last → 8 consecutive det_pulses; match_cnt=8; thresh_hit rises in the same cycle match_cnt=3 and stays high after done.
4. Pulse cfg_we with len=2 and start during SHIFT → both ignored; pattern, len and count unaffected; a later start in IDLE clears match_cnt and thresh_hit to 0.
5. Hold in_valid=0 for 5 cycles in LOAD → in_ready stays 1, busy=1, no shifting and no det_pulse; the scan resumes correctly when in_valid=1.
6. Assert rst=0 asynchronously mid-SHIFT → all outputs 0 immediately, IDLE, no done; after release, len=0, so no matches on a fresh scan until reconfigured.
